// File: rtl/addsub_pipe.sv
// Pipelined integer adder/subtractor; the carry chain is split into STAGES registered segments.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output `ovf`.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int unsigned SEG  = (WIDTH + STAGES - 1) / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] load;

  // Load enables ripple back from the output so a full pipeline can still stream.
  always_comb begin
    load = '0;
    load[LAST] = !valid[LAST] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      load[k] = !valid[k] || load[k+1];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int Lo = int'(k * SEG);
    localparam int Hi = ((k + 1) * SEG > WIDTH) ? int'(WIDTH) : int'((k + 1) * SEG);

    logic [WIDTH-1:0] a_in, b_in, r_in, r_nx;
    logic             c_in, c_nx, v_in;
    logic             v_q, c_q;
    logic [WIDTH-1:0] r_q;

    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign a_in = reg1;
      assign b_in = reg2 ^ {WIDTH{op}};
      assign c_in = op;
      assign r_in = '0;
    end else begin : g_body
      assign v_in = g_stage[k-1].v_q;
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign r_in = g_stage[k-1].r_q;
    end

    // Ripple only the bits owned by this segment; lower bits pass through unchanged.
    always_comb begin
      r_nx = r_in;
      c_nx = c_in;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i >= Lo && i < Hi) begin
          r_nx[i] = a_in[i] ^ b_in[i] ^ c_nx;
          c_nx    = (a_in[i] & b_in[i]) | (c_nx & (a_in[i] ^ b_in[i]));
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (load[k]) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= c_nx;
          r_q <= r_nx;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q, b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load[k] && v_in) begin
          a_q <= a_in;
          b_q <= b_in;
        end
      end
    end

    assign valid[k] = v_q;
  end

  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
    end else if (load[LAST] && g_stage[LAST].v_in) begin
      zero_q <= (g_stage[LAST].r_nx == '0);
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_q;

  // Carry into the MSB is recovered from its sum bit: a ^ b ^ sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (load[LAST] && g_stage[LAST].v_in) begin
      ovf_q <= g_stage[LAST].a_in[WIDTH-1] ^ g_stage[LAST].b_in[WIDTH-1] ^
               g_stage[LAST].r_nx[WIDTH-1] ^ g_stage[LAST].c_nx;
    end
  end

  assign ovf = ovf_q;
`endif

  assign out_valid = valid[LAST];
  assign result    = g_stage[LAST].r_q;
  assign cout      = g_stage[LAST].c_q;
  assign zero      = zero_q;

endmodule
